multi_alarm_timekeeper: RTL

//  BCD time-of-day core with NUM_ALARMS independently enabled alarms, a ring/snooze FSM
//  and an optional hourly chime. Replaces the single-alarm counter_sec/min/hour + alarm chain.

---
 rtl/clock_pkg.sv | 34 +++
 rtl/bcd_counter_mod.sv | 30 +++
 rtl/multi_alarm_timekeeper.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the time-of-day core and its alarm/ring logic.
// Pure declarations: no state, no timing of its own.
package clock_pkg;

   typedef logic [7:0] bcd8_t;

   typedef struct packed {
      bcd8_t hour;
      bcd8_t min;
      bcd8_t sec;
   } time_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } ring_state_e;

   localparam bcd8_t MAX_SEC  = 8'h59;
   localparam bcd8_t MAX_MIN  = 8'h59;
   localparam bcd8_t MAX_HOUR = 8'h23;

   // Both digits decimal and the value within the field's range.
   function automatic logic bcd_valid(input bcd8_t v, input bcd8_t lim);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
   endfunction

   function automatic bcd8_t bcd_inc(input bcd8_t v, input bcd8_t lim);
      if (v >= lim) return '0;
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return v + 8'd1;
   endfunction

endpackage

// File: rtl/bcd_counter_mod.sv
// Two-digit BCD modulo counter (0..MOD_MAX); load beats enable, carry is combinational.
// Latency: q updates on the edge after en/load; no backpressure, en and load always accepted.
module bcd_counter_mod
   import clock_pkg::*;
#(
   parameter bcd8_t MOD_MAX = 8'h59
) (
   input  logic  CP,
   input  logic  _CR,
   input  logic  en,
   input  logic  load,
   input  bcd8_t load_val,
   output bcd8_t q,
   output logic  carry
);

   always_ff @(posedge CP or negedge _CR) begin
      if (!_CR) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (en) begin
         q <= bcd_inc(q, MOD_MAX);
      end
   end

   // High in the cycle whose enable wraps the counter back to 00.
   assign carry = en && !load && (q == MOD_MAX);

endmodule

// File: rtl/multi_alarm_timekeeper.sv
// BCD time-of-day with NUM_ALARMS alarm slots, ring/snooze FSM; HOURLY_CHIME_EN adds the hourly chime.
// Latency: all outputs registered, one cycle after the tick/strobe; no backpressure, strobes always accepted.
module multi_alarm_timekeeper
   import clock_pkg::*;
#(
   parameter  int NUM_ALARMS = 4,
   parameter  int RING_SECS  = 60,
   parameter  int SNOOZE_MIN = 5,
   localparam int IW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  CP,
   input  logic                  _CR,
   input  logic                  tick_1hz,
   input  logic                  set_en,
   input  logic [23:0]           set_time,
   output logic                  set_err,
   input  logic                  alm_we,
   input  logic [IW-1:0]         alm_idx,
   input  logic [15:0]           alm_time,
   input  logic [NUM_ALARMS-1:0] alm_enable,
   input  logic                  snooze,
   input  logic                  dismiss,
   output logic [23:0]           show_time,
   output logic                  ring,
   output logic [IW-1:0]         ring_idx,
   output logic                  chime
);

   localparam logic [7:0]  RING_LOAD = 8'(RING_SECS);
   localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * 60);

   time_t set_t;
   logic  set_valid;
   logic  set_ok;
   logic  set_err_q;
   logic  tick_eff;

   bcd8_t sec_q, min_q, hour_q;
   logic  sec_carry, min_carry, hour_carry_unused;

   assign set_t     = set_time;
   assign set_valid = bcd_valid(set_t.hour, MAX_HOUR) &&
                      bcd_valid(set_t.min,  MAX_MIN)  &&
                      bcd_valid(set_t.sec,  MAX_SEC);
   assign set_ok    = set_en && set_valid;
   // A tick colliding with a set strobe is dropped.
   assign tick_eff  = tick_1hz && !set_en;

   bcd_counter_mod #(.MOD_MAX(MAX_SEC)) u_sec (
      .CP       (CP),
      ._CR      (_CR),
      .en       (tick_eff),
      .load     (set_ok),
      .load_val (set_t.sec),
      .q        (sec_q),
      .carry    (sec_carry)
   );

   bcd_counter_mod #(.MOD_MAX(MAX_MIN)) u_min (
      .CP       (CP),
      ._CR      (_CR),
      .en       (sec_carry),
      .load     (set_ok),
      .load_val (set_t.min),
      .q        (min_q),
      .carry    (min_carry)
   );

   bcd_counter_mod #(.MOD_MAX(MAX_HOUR)) u_hour (
      .CP       (CP),
      ._CR      (_CR),
      .en       (min_carry),
      .load     (set_ok),
      .load_val (set_t.hour),
      .q        (hour_q),
      .carry    (hour_carry_unused)
   );

   always_ff @(posedge CP or negedge _CR) begin
      if (!_CR) begin
         set_err_q <= 1'b0;
      end else begin
         set_err_q <= set_en && !set_valid;
      end
   end

   assign set_err   = set_err_q;
   assign show_time = {hour_q, min_q, sec_q};

   // Alarm slot storage, {hour,min} BCD per slot.
   logic [15:0] slot_hm [NUM_ALARMS];
   logic        alm_ok;

   assign alm_ok = bcd_valid(alm_time[15:8], MAX_HOUR) && bcd_valid(alm_time[7:0], MAX_MIN);

   always_ff @(posedge CP or negedge _CR) begin
      if (!_CR) begin
         for (int i = 0; i < NUM_ALARMS; i++) slot_hm[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (alm_we && alm_ok && (alm_idx == IW'(i))) slot_hm[i] <= alm_time;
         end
      end
   end

   // Matching uses the {hour,min} the counters are about to take on this tick.
   bcd8_t          next_min, next_hour;
   logic           match_any;
   logic [IW-1:0]  match_idx;

   assign next_min  = bcd_inc(min_q, MAX_MIN);
   assign next_hour = (min_q == MAX_MIN) ? bcd_inc(hour_q, MAX_HOUR) : hour_q;

   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (sec_carry && alm_enable[i] && (slot_hm[i] == {next_hour, next_min})) begin
            match_any = 1'b1;
            match_idx = IW'(i);
         end
      end
   end

   ring_state_e   state, state_nxt;
   logic [7:0]    ring_cnt, ring_cnt_nxt;
   logic [11:0]   snz_cnt, snz_cnt_nxt;
   logic [IW-1:0] ring_idx_q, ring_idx_nxt;
   logic          idx_armed;

   assign idx_armed = alm_enable[ring_idx_q];

   always_ff @(posedge CP or negedge _CR) begin
      if (!_CR) begin
         state      <= IDLE;
         ring_cnt   <= '0;
         snz_cnt    <= '0;
         ring_idx_q <= '0;
      end else begin
         state      <= state_nxt;
         ring_cnt   <= ring_cnt_nxt;
         snz_cnt    <= snz_cnt_nxt;
         ring_idx_q <= ring_idx_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      ring_cnt_nxt = ring_cnt;
      snz_cnt_nxt  = snz_cnt;
      ring_idx_nxt = ring_idx_q;
      case (state)
         IDLE: begin
            if (match_any) begin
               state_nxt    = RING;
               ring_idx_nxt = match_idx;
               ring_cnt_nxt = RING_LOAD;
            end
         end
         RING: begin
            if (dismiss || !idx_armed) begin
               state_nxt = IDLE;
            end else if (snooze) begin
               state_nxt   = SNOOZE;
               snz_cnt_nxt = SNZ_LOAD;
            end else if (tick_1hz && (ring_cnt != 8'd0)) begin
               ring_cnt_nxt = ring_cnt - 8'd1;
               if (ring_cnt == 8'd1) state_nxt = IDLE;
            end
         end
         SNOOZE: begin
            if (dismiss || !idx_armed) begin
               state_nxt = IDLE;
            end else if (match_any) begin
               // A fresh alarm preempts the pending snooze.
               state_nxt    = RING;
               ring_idx_nxt = match_idx;
               ring_cnt_nxt = RING_LOAD;
            end else if (tick_1hz && (snz_cnt != 12'd0)) begin
               snz_cnt_nxt = snz_cnt - 12'd1;
               if (snz_cnt == 12'd1) begin
                  state_nxt    = RING;
                  ring_cnt_nxt = RING_LOAD;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign ring     = (state == RING);
   assign ring_idx = ring_idx_q;

`ifdef HOURLY_CHIME_EN
   logic chime_q;
   logic ring_start;

   assign ring_start = (state_nxt == RING) && (state != RING);

   // Hour rollover raises the chime for one second unless an alarm starts ringing on that tick.
   always_ff @(posedge CP or negedge _CR) begin
      if (!_CR) begin
         chime_q <= 1'b0;
      end else if (tick_1hz) begin
         chime_q <= min_carry && !ring_start;
      end
   end

   assign chime = chime_q;
`else
   assign chime = 1'b0;
`endif

endmodule
